uart_tx_fifo: RTL and testbench

- Transmit-side buffer and launcher directly upstream of the bootloader's byte-serial UART transmitter.
- Accepts bytes from bootloader logic in bursts and stores them in a synchronous FIFO.
- Feeds the transmitter one byte at a time using its data-valid pulse / done pulse handshake, so producers never have to track the 10-bit frame time.

---
 rtl/uart_tx_fifo.sv | 129 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of a DV/done-handshake UART transmitter.
// Launches one queued byte per frame; launches wait while the transmitter is active.
module uart_tx_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          i_Clock,
  input  logic          i_Rst_n,
  input  logic          i_Wr_DV,
  input  logic [7:0]    i_Wr_Byte,
  input  logic          i_Clr_Ovf,
  output logic          o_Full,
  output logic          o_Empty,
  output logic [AW:0]   o_Count,
  output logic          o_Overflow,
  output logic          o_Busy,
  output logic          o_Tx_DV,
  output logic [7:0]    o_Tx_Byte,
  input  logic          i_Tx_Active,
  input  logic          i_Tx_Done
);

  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_WAIT   = 2'd1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  logic [7:0]    r_Mem [DEPTH];
  logic [AW-1:0] r_Wr_Ptr;
  logic [AW-1:0] r_Rd_Ptr;
  logic [AW:0]   r_Count;
  logic [1:0]    r_State;
  logic          r_Full;
  logic          r_Empty;
  logic          r_Overflow;
  logic          r_Tx_DV;
  logic [7:0]    r_Tx_Byte;

  logic          w_Full;
  logic          w_Wr_Acc;
  logic          w_Pop;
  logic [AW:0]   w_Count_Nxt;

  // Fullness is judged on the pre-pop count, so a pop never frees
  // space for a write in the same cycle.
  assign w_Full   = (r_Count == FULL_CNT);
  assign w_Wr_Acc = i_Wr_DV & ~w_Full;
  assign w_Pop    = (r_State == S_IDLE) & (r_Count != '0) & ~i_Tx_Active;

  always_comb begin
    w_Count_Nxt = r_Count;
    unique case (1'b1)
      (w_Wr_Acc & ~w_Pop): w_Count_Nxt = r_Count + ONE;
      (w_Pop & ~w_Wr_Acc): w_Count_Nxt = r_Count - ONE;
      default:             w_Count_Nxt = r_Count;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (w_Wr_Acc) begin
      r_Mem[r_Wr_Ptr] <= i_Wr_Byte;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_Wr_Ptr <= '0;
      r_Rd_Ptr <= '0;
      r_Count  <= '0;
      r_Full   <= 1'b0;
      r_Empty  <= 1'b1;
    end else begin
      if (w_Wr_Acc) begin
        r_Wr_Ptr <= r_Wr_Ptr + 1'b1;
      end
      if (w_Pop) begin
        r_Rd_Ptr <= r_Rd_Ptr + 1'b1;
      end
      r_Count <= w_Count_Nxt;
      r_Full  <= (w_Count_Nxt == FULL_CNT);
      r_Empty <= (w_Count_Nxt == '0);
    end
  end

  // A dropped write outranks a same-cycle clear.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_Overflow <= 1'b0;
    end else if (i_Wr_DV & w_Full) begin
      r_Overflow <= 1'b1;
    end else if (i_Clr_Ovf) begin
      r_Overflow <= 1'b0;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_State   <= S_IDLE;
      r_Tx_DV   <= 1'b0;
      r_Tx_Byte <= 8'h00;
    end else begin
      r_Tx_DV <= 1'b0;
      case (r_State)
        S_IDLE: begin
          if (w_Pop) begin
            r_Tx_DV   <= 1'b1;
            r_Tx_Byte <= r_Mem[r_Rd_Ptr];
            r_State   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_Tx_Done) begin
            r_State <= S_IDLE;
          end
        end
        default: r_State <= S_IDLE;
      endcase
    end
  end

  assign o_Full     = r_Full;
  assign o_Empty    = r_Empty;
  assign o_Count    = r_Count;
  assign o_Overflow = r_Overflow;
  assign o_Busy     = (r_Count != '0) | (r_State == S_WAIT);
  assign o_Tx_DV    = r_Tx_DV;
  assign o_Tx_Byte  = r_Tx_Byte;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: queue-based model, transmitter/receiver models,
// directed vectors with literal expectations.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_Wr_DV = 1'b0;
  logic [7:0] i_Wr_Byte = 8'h00;
  logic       i_Clr_Ovf = 1'b0;
  logic       o_Full;
  logic       o_Empty;
  logic [4:0] o_Count;
  logic       o_Overflow;
  logic       o_Busy;
  logic       o_Tx_DV;
  logic [7:0] o_Tx_Byte;

  logic       tx_active = 1'b0;
  logic       tx_done = 1'b0;
  logic       tx_line = 1'b1;
  logic       stall = 1'b0;
  logic       act_in;
  int         cpb = 104;

  assign act_in = tx_active | stall;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .i_Clock    (clk),
    .i_Rst_n    (rst_n),
    .i_Wr_DV    (i_Wr_DV),
    .i_Wr_Byte  (i_Wr_Byte),
    .i_Clr_Ovf  (i_Clr_Ovf),
    .o_Full     (o_Full),
    .o_Empty    (o_Empty),
    .o_Count    (o_Count),
    .o_Overflow (o_Overflow),
    .o_Busy     (o_Busy),
    .o_Tx_DV    (o_Tx_DV),
    .o_Tx_Byte  (o_Tx_Byte),
    .i_Tx_Active(act_in),
    .i_Tx_Done  (tx_done)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h want 0x%0h at %0t",
                  nm, act, exp, $time);
  endtask

  int cyc_n = 0;
  always @(posedge clk) cyc_n++;

  // transmitter without reset: start, 8 data LSB-first, stop, cleanup
  int         tx_ph = 0;
  int         tx_bit = 0;
  int         tx_cnt = 0;
  logic [7:0] tx_sh = 8'h00;

  always @(posedge clk) begin
    tx_done <= 1'b0;
    case (tx_ph)
      0: if (o_Tx_DV) begin
        tx_sh     <= o_Tx_Byte;
        tx_active <= 1'b1;
        tx_line   <= 1'b0;
        tx_bit    <= 0;
        tx_cnt    <= 0;
        tx_ph     <= 1;
      end
      1: if (tx_cnt < cpb - 1) tx_cnt <= tx_cnt + 1;
      else begin
        tx_cnt <= 0;
        if (tx_bit == 9) begin
          tx_done   <= 1'b1;
          tx_active <= 1'b0;
          tx_ph     <= 2;
        end else begin
          tx_bit  <= tx_bit + 1;
          tx_line <= (tx_bit == 8) ? 1'b1 : tx_sh[tx_bit[2:0]];
        end
      end
      default: tx_ph <= 0;
    endcase
  end

  // behavioural model: a queue plus a "frame outstanding" flag
  logic [7:0] mq[$];
  logic [7:0] sentq[$];
  logic       m_wait = 1'b0;
  logic       m_ovf = 1'b0;
  logic       m_dv = 1'b0;
  logic [7:0] m_byte = 8'h00;
  logic       m_launch;
  logic       m_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_wait = 1'b0;
      m_ovf  = 1'b0;
      m_dv   = 1'b0;
      m_byte = 8'h00;
    end else begin
      m_launch = !m_wait && mq.size() != 0 && !act_in;
      m_acc    = i_Wr_DV && mq.size() < DEPTH;
      if (i_Wr_DV && !m_acc) m_ovf = 1'b1;
      else if (i_Clr_Ovf) m_ovf = 1'b0;
      m_dv = m_launch;
      if (m_launch) begin
        m_byte = mq.pop_front();
        sentq.push_back(m_byte);
      end
      if (m_acc) mq.push_back(i_Wr_Byte);
      if (m_launch) m_wait = 1'b1;
      else if (m_wait && tx_done) m_wait = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("count", o_Count, mq.size());
    chk("full", o_Full, mq.size() == DEPTH);
    chk("empty", o_Empty, mq.size() == 0);
    chk("overflow", o_Overflow, m_ovf);
    chk("busy", o_Busy, mq.size() != 0 || m_wait);
    chk("tx_dv", o_Tx_DV, m_dv);
    chk("tx_byte", o_Tx_Byte, m_byte);
  end

  int dv_cnt = 0;
  int dv_cyc = 0;
  always @(negedge clk) begin
    if (o_Tx_DV) begin
      dv_cnt++;
      dv_cyc = cyc_n;
    end
  end

  // line receiver: mid-bit sampling
  logic [9:0] last_bits = '0;
  logic [7:0] rx_log[$];
  int         rx_total = 0;

  initial begin
    logic [9:0] bits;
    forever begin
      @(posedge clk);
      if (tx_line == 1'b0) begin
        repeat (cpb / 2) @(posedge clk);
        bits[0] = tx_line;
        for (int b = 1; b < 10; b++) begin
          repeat (cpb) @(posedge clk);
          bits[b] = tx_line;
        end
        last_bits = bits;
        rx_total++;
        rx_log.push_back(bits[8:1]);
        chk("rx_start", bits[0], 0);
        chk("rx_stop", bits[9], 1);
        if (sentq.size() == 0) chk("rx_extra", sentq.size(), 1);
        else chk("rx_byte", bits[8:1], sentq.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] b);
    i_Wr_DV   = 1'b1;
    i_Wr_Byte = b;
    step(1);
    i_Wr_DV   = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    while ((o_Busy || tx_ph != 0) && n < budget) begin
      step(1);
      n++;
    end
    chk({nm, "_idle"}, o_Busy || tx_ph != 0, 0);
    step(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [7:0] burst [4] = '{8'h55, 8'h0F, 8'hF0, 8'hC3};

  initial begin
    int t0;
    int dv0;
    int n;

    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    chk("rst_count", o_Count, 0);
    chk("rst_empty", o_Empty, 1);
    chk("rst_full", o_Full, 0);
    chk("rst_dv", o_Tx_DV, 0);
    chk("rst_byte", o_Tx_Byte, 0);

    // single byte, written on edge 10
    while (cyc_n < 9) step(1);
    t0 = cyc_n;
    wr(8'hA5);
    wait_idle(1500, "single");
    chk("single_dv_lat", dv_cyc - t0, 2);
    chk("single_dv_cnt", dv_cnt, 1);
    chk("single_rx", rx_log[0], 8'hA5);
    chk("single_line", last_bits, 10'b1101001010);
    chk("single_busy", o_Busy, 0);

    // burst; first byte launches while the rest are still arriving
    cpb = 4;
    for (int i = 0; i < 4; i++) begin
      i_Wr_DV   = 1'b1;
      i_Wr_Byte = burst[i];
      step(1);
    end
    i_Wr_DV = 1'b0;
    chk("burst_count", o_Count, 3);
    wait_idle(400, "burst");
    for (int i = 0; i < 4; i++) chk("burst_rx", rx_log[1 + i], burst[i]);
    chk("burst_dv_cnt", dv_cnt, 5);

    // fill with transmitter stalled, then overflow
    stall = 1'b1;
    for (int i = 0; i < 17; i++) wr(8'(8'h80 + i));
    chk("full_flag", o_Full, 1);
    chk("full_count", o_Count, 16);
    chk("full_ovf", o_Overflow, 1);
    i_Wr_DV   = 1'b1;
    i_Wr_Byte = 8'hEE;
    i_Clr_Ovf = 1'b1;
    step(1);
    i_Wr_DV   = 1'b0;
    i_Clr_Ovf = 1'b0;
    chk("ovf_set_wins", o_Overflow, 1);
    i_Clr_Ovf = 1'b1;
    step(1);
    i_Clr_Ovf = 1'b0;
    chk("ovf_cleared", o_Overflow, 0);
    stall = 1'b0;
    wait_idle(1200, "full");
    chk("full_last_rx", rx_log[20], 8'h8F);
    chk("full_rx_total", rx_total, 21);

    // wrap-around with random gaps
    for (int i = 0; i < 40; i++) begin
      n = 0;
      while (o_Full && n < 2000) begin
        step(1);
        n++;
      end
      if (n >= 2000) chk("wrap_full_wait", o_Full, 0);
      wr(8'(i));
      step($urandom_range(0, 3));
    end
    wait_idle(2500, "wrap");
    for (int i = 0; i < 40; i++) chk("wrap_rx", rx_log[21 + i], i);
    chk("wrap_rx_total", rx_total, 61);

    // write coinciding with a launch from count 1
    stall = 1'b1;
    wr(8'h11);
    step(1);
    stall     = 1'b0;
    i_Wr_DV   = 1'b1;
    i_Wr_Byte = 8'h22;
    step(1);
    i_Wr_DV   = 1'b0;
    chk("simul_count", o_Count, 1);
    chk("simul_dv", o_Tx_DV, 1);
    chk("simul_byte", o_Tx_Byte, 8'h11);
    wait_idle(300, "simul");
    chk("simul_rx0", rx_log[61], 8'h11);
    chk("simul_rx1", rx_log[62], 8'h22);

    // reset during data bit 3 with three bytes queued
    for (int i = 0; i < 4; i++) begin
      i_Wr_DV   = 1'b1;
      i_Wr_Byte = 8'(8'hD1 + i);
      step(1);
    end
    i_Wr_DV = 1'b0;
    n = 0;
    while (!(tx_ph == 1 && tx_bit == 4) && n < 200) begin
      step(1);
      n++;
    end
    chk("mid_reach_bit3", tx_bit, 4);
    chk("mid_queued", o_Count, 3);
    dv0   = dv_cnt;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    chk("mid_count", o_Count, 0);
    chk("mid_empty", o_Empty, 1);
    chk("mid_busy", o_Busy, 0);
    n = 0;
    while (tx_ph != 0 && n < 200) begin
      step(1);
      n++;
    end
    chk("mid_tx_end", tx_ph, 0);
    step(3);
    chk("mid_no_dv", dv_cnt, dv0);
    wr(8'h3C);
    wait_idle(300, "mid");
    chk("mid_rx_inflight", rx_log[63], 8'hD1);
    chk("mid_rx_new", rx_log[64], 8'h3C);
    chk("final_rx_total", rx_total, 65);
    chk("final_sentq", sentq.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
